sprite_motion_engine: RTL and testbench

- Parametrised successor to the single-ball motion block. Tracks N_OBJ square sprites.
- Updates every sprite once per video frame: object 0 is steered by the USB keycode, the rest move autonomously.
- Edges are handled as bounce or wrap-around, selectable by parameter.
- Sits between the NIOS keycode PIO / VGA sync and the colour mapper. Publishes a tear-free, double-buffered position set.

---
 rtl/sprite_motion_engine.sv | 208 ++++++++++++++++++++
 tb/tb_sprite_motion_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_engine.sv
// Per-frame motion engine for N_OBJ square sprites. Object 0 is steered by a
// USB keycode, the others move on their own. The working set is updated one
// object per cycle after a vs rising edge and then published in one shot, so
// the colour mapper never sees a half-updated frame.
module sprite_motion_engine #(
    parameter int N_OBJ   = 4,
    parameter int W       = 10,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int SIZE    = 4,
    parameter int STEP    = 1,
    parameter int SPACING = 64,
    parameter int WRAP    = 0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               vs,
    input  logic               pause,
    input  logic [7:0]         keycode,
    output logic [N_OBJ*W-1:0] obj_x,
    output logic [N_OBJ*W-1:0] obj_y,
    output logic [W-1:0]       obj_size,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int PW = W + 2;

    typedef enum logic [1:0] {IDLE, UPDATE, PUBLISH} state_t;

    // One axis of one object: position (unsigned) and velocity (signed bits).
    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] v;
    } axis_t;

    // Edge handling for one axis; W+2 bits keep p+SIZE and p+v from overflowing.
    function automatic axis_t step_axis(input logic [W-1:0] p, input logic [W-1:0] v,
                                        input int lo, input int hi);
        logic signed [PW-1:0] ps, vel, lo_s, hi_s, sz, st, pn, vn;
        axis_t r;
        ps   = signed'({2'b00, p});
        vel  = signed'({{2{v[W-1]}}, v});
        lo_s = PW'(lo);
        hi_s = PW'(hi);
        sz   = PW'(SIZE);
        st   = PW'(STEP);
        if (WRAP == 0) begin
            // Bounce: the boundary wins over whatever velocity came in.
            if (ps + sz >= hi_s)      vn = -st;
            else if (ps <= lo_s + sz) vn = st;
            else                      vn = vel;
            pn = ps + vn;
        end else begin
            // Wrap: velocity is never touched, only the position jumps.
            vn = vel;
            if (ps + sz >= hi_s && vel > 0)      pn = lo_s + sz;
            else if (ps <= lo_s + sz && vel < 0) pn = hi_s - sz;
            else                                 pn = ps + vel;
        end
        r.p = W'(pn);
        r.v = W'(vn);
        return r;
    endfunction

    function automatic logic [W-1:0] rst_x(input int i);
        return (i == 0) ? W'(320) : W'(X_MIN + i * SPACING);
    endfunction

    function automatic logic [W-1:0] rst_vx(input int i);
        if (i == 0) return '0;
        return (i % 2 == 1) ? W'(-STEP) : W'(STEP);
    endfunction

    function automatic logic [W-1:0] rst_vy(input int i);
        return (i == 0) ? W'(0) : W'(STEP);
    endfunction

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           vs_d_q;
    logic           pause_q;
    logic [7:0]     key_q;
    logic [W-1:0]   x_q  [N_OBJ];
    logic [W-1:0]   y_q  [N_OBJ];
    logic [W-1:0]   vx_q [N_OBJ];
    logic [W-1:0]   vy_q [N_OBJ];
    logic [W-1:0]   x_d  [N_OBJ];
    logic [W-1:0]   y_d  [N_OBJ];
    logic [W-1:0]   vx_d [N_OBJ];
    logic [W-1:0]   vy_d [N_OBJ];
    logic           frame_edge;
    logic           last_obj;
    logic [W-1:0]   key_vx, key_vy;
    axis_t          ax, ay;

    assign frame_edge = vs & ~vs_d_q;
    assign last_obj   = (state_q == UPDATE) && (idx_q == IW'(N_OBJ - 1));
    assign obj_size   = W'(SIZE);

    // Next state and frame index.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == IW'(N_OBJ - 1)) state_d = PUBLISH;
                else                         idx_d   = idx_q + 1'b1;
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Motion of the object currently selected by idx, merged into the working set.
    always_comb begin
        key_vx = vx_q[idx_q];
        key_vy = vy_q[idx_q];
        if (idx_q == '0) begin
            case (key_q)
                8'h1A:   begin key_vx = '0;        key_vy = W'(-STEP); end
                8'h16:   begin key_vx = '0;        key_vy = W'(STEP);  end
                8'h04:   begin key_vx = W'(-STEP); key_vy = '0;        end
                8'h07:   begin key_vx = W'(STEP);  key_vy = '0;        end
                default: ;
            endcase
        end
        ax = step_axis(x_q[idx_q], key_vx, X_MIN, X_MAX);
        ay = step_axis(y_q[idx_q], key_vy, Y_MIN, Y_MAX);
        for (int i = 0; i < N_OBJ; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            vx_d[i] = vx_q[i];
            vy_d[i] = vy_q[i];
        end
        if (state_q == UPDATE && !pause_q) begin
            x_d[idx_q]  = ax.p;
            y_d[idx_q]  = ay.p;
            vx_d[idx_q] = ax.v;
            vy_d[idx_q] = ay.v;
        end
    end

    // Control registers: FSM, edge detect, frame-latched inputs, status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vs_d_q  <= 1'b0;
            pause_q <= 1'b0;
            key_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            vs_d_q  <= vs;
            busy    <= (state_d == UPDATE);
            done    <= (state_d == PUBLISH);
            if (frame_edge && state_q != IDLE) overrun <= 1'b1;
            if (frame_edge && state_q == IDLE) begin
                pause_q <= pause;
                key_q   <= keycode;
            end
        end
    end

    // Working set and published set; the published copy takes the merged
    // working values on the last update cycle so it is valid while done is high.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: these arrays are real state with defined start positions, so they are reset element by element.
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]            <= rst_x(i);
                y_q[i]            <= W'(240);
                vx_q[i]           <= rst_vx(i);
                vy_q[i]           <= rst_vy(i);
                obj_x[i*W +: W]   <= rst_x(i);
                obj_y[i*W +: W]   <= W'(240);
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                vx_q[i] <= vx_d[i];
                vy_q[i] <= vy_d[i];
                if (last_obj) begin
                    obj_x[i*W +: W] <= x_d[i];
                    obj_y[i*W +: W] <= y_d[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Bench for sprite_motion_engine: a bounce instance and a wrap instance share
// one stimulus stream; a behavioural model queues the expected position set
// per frame and each done pulse pops and compares it.
module tb_sprite_motion_engine;

    localparam int N = 4;
    localparam int W = 10;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           vs;
    logic           pause;
    logic [7:0]     keycode;
    logic [N*W-1:0] x0, y0, x1, y1;
    logic [W-1:0]   sz0, sz1;
    logic           busy0, done0, ovr0, busy1, done1, ovr1;

    int total = 0;
    int bad   = 0;

    int mx  [2][N];
    int my  [2][N];
    int mvx [2][N];
    int mvy [2][N];

    logic [2*N*W-1:0] q0 [$];
    logic [2*N*W-1:0] q1 [$];

    always #10 Clk = ~Clk;

    sprite_motion_engine #(.N_OBJ(N), .W(W), .WRAP(0)) u_bounce (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .pause(pause), .keycode(keycode),
        .obj_x(x0), .obj_y(y0), .obj_size(sz0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    sprite_motion_engine #(.N_OBJ(N), .W(W), .WRAP(1)) u_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .pause(pause), .keycode(keycode),
        .obj_x(x1), .obj_y(y1), .obj_size(sz1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
                mx[m][i]  = (i == 0) ? 320 : i * 64;
                my[m][i]  = 240;
                mvx[m][i] = (i == 0) ? 0 : ((i % 2 == 1) ? -1 : 1);
                mvy[m][i] = (i == 0) ? 0 : 1;
            end
    endtask

    task automatic model_axis(input int p, input int v, input int lo, input int hi,
                              input int wrap, output int po, output int vo);
        vo = v;
        if (wrap == 0) begin
            if (p + 4 >= hi)      vo = -1;
            else if (p <= lo + 4) vo = 1;
            po = p + vo;
        end else begin
            if (p + 4 >= hi && v > 0)      po = lo + 4;
            else if (p <= lo + 4 && v < 0) po = hi - 4;
            else                           po = p + v;
        end
    endtask

    task automatic model_frame(input int m, input logic [7:0] key, input bit pse);
        int vx, vy, px, py, nvx, nvy;
        if (pse) return;
        for (int i = 0; i < N; i++) begin
            vx = mvx[m][i];
            vy = mvy[m][i];
            if (i == 0) begin
                if (key == 8'h1A)      begin vx = 0;  vy = -1; end
                else if (key == 8'h16) begin vx = 0;  vy = 1;  end
                else if (key == 8'h04) begin vx = -1; vy = 0;  end
                else if (key == 8'h07) begin vx = 1;  vy = 0;  end
            end
            model_axis(mx[m][i], vx, 0, 639, m, px, nvx);
            model_axis(my[m][i], vy, 0, 479, m, py, nvy);
            mx[m][i]  = px;  my[m][i]  = py;
            mvx[m][i] = nvx; mvy[m][i] = nvy;
        end
    endtask

    function automatic logic [2*N*W-1:0] model_vec(input int m);
        logic [2*N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[N*W + i*W +: W] = W'(mx[m][i]);
            r[i*W +: W]       = W'(my[m][i]);
        end
        return r;
    endfunction

    task automatic pop_compare(input int m, input string tag);
        logic [2*N*W-1:0] e;
        if (m == 0) begin
            if (q0.size() == 0) begin check({tag, "_q0_empty"}, 1, 0); return; end
            e = q0.pop_front();
            check({tag, "_b_x"}, 64'(x0), 64'(e[N*W +: N*W]));
            check({tag, "_b_y"}, 64'(y0), 64'(e[0 +: N*W]));
        end else begin
            if (q1.size() == 0) begin check({tag, "_q1_empty"}, 1, 0); return; end
            e = q1.pop_front();
            check({tag, "_w_x"}, 64'(x1), 64'(e[N*W +: N*W]));
            check({tag, "_w_y"}, 64'(y1), 64'(e[0 +: N*W]));
        end
    endtask

    // One frame: raise vs, optionally re-pulse it during UPDATE, watch busy/done.
    task automatic run_frame(input logic [7:0] key, input bit pse, input bit dbl, input string tag);
        logic [2*N*W-1:0] prev;
        int nbusy, ndone, dcyc;
        prev = model_vec(0);
        @(posedge Clk); #1;
        keycode = key;
        pause   = pse;
        vs      = 1'b1;
        model_frame(0, key, pse);
        model_frame(1, key, pse);
        q0.push_back(model_vec(0));
        q1.push_back(model_vec(1));
        nbusy = 0; ndone = 0; dcyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clk); #1;
            if (busy0) nbusy++;
            if (done0) begin ndone++; dcyc = c; pop_compare(0, tag); end
            if (done1) pop_compare(1, tag);
            if (c == 4) check({tag, "_hold"}, 64'(x0), 64'(prev[N*W +: N*W]));
            if (c == 1) vs = 1'b0;
            if (dbl && c == 2) vs = 1'b1;
            if (dbl && c == 3) vs = 1'b0;
        end
        check({tag, "_busy_cycles"}, nbusy, 4);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_done_cycle"}, dcyc, 5);
    endtask

    initial begin
        logic [2*N*W-1:0] rv;
        int guard;
        Reset_n = 1'b0; vs = 1'b0; pause = 1'b0; keycode = 8'h00;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        rv = model_vec(0);
        check("rst_x", 64'(x0), 64'(rv[N*W +: N*W]));
        check("rst_y", 64'(y0), 64'(rv[0 +: N*W]));
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ovr", ovr0, 0);
        check("obj_size", sz0, 4);
        @(negedge Clk) Reset_n = 1'b1;

        run_frame(8'h00, 0, 0, "f1");
        check("f1_o0x", x0[0 +: W], 320);
        check("f1_o1x", x0[W +: W], 63);
        check("f1_o1y", y0[W +: W], 241);
        check("f1_o2x", x0[2*W +: W], 129);
        check("f1_o3x", x0[3*W +: W], 191);
        check("f1_o3y", y0[3*W +: W], 241);

        repeat (3) run_frame(8'h07, 0, 0, "right");
        check("right_o0x", x0[0 +: W], 323);
        check("right_o0y", y0[0 +: W], 240);
        repeat (2) run_frame(8'h1A, 0, 0, "up");
        check("up_o0x", x0[0 +: W], 323);
        check("up_o0y", y0[0 +: W], 238);
        check("pre_ovr", ovr0, 0);

        guard = 0;
        while (mx[0][0] != 5 && guard < 400) begin
            run_frame(8'h04, 0, 0, "left");
            guard++;
        end
        check("left_reached5", x0[0 +: W], 5);
        run_frame(8'h04, 0, 0, "edge");
        check("edge_b_x", x0[0 +: W], 4);
        check("edge_w_x", x1[0 +: W], 4);
        run_frame(8'h04, 0, 0, "bounce");
        check("bounce_b_x", x0[0 +: W], 5);
        check("wrap_w_x", x1[0 +: W], 635);
        run_frame(8'h04, 0, 0, "after");
        check("after_w_x", x1[0 +: W], 634);

        run_frame(8'h07, 1, 0, "pause");
        check("pause_b_x", x0[0 +: W], 4);
        check("pause_w_x", x1[0 +: W], 634);

        run_frame(8'h00, 0, 1, "dbl");
        check("dbl_ovr", ovr0, 1);
        run_frame(8'h00, 0, 0, "clean");
        check("clean_ovr", ovr0, 1);

        // Reset asserted two cycles after the edge, in the middle of UPDATE.
        @(posedge Clk); #1 vs = 1'b1;
        @(posedge Clk); #1 vs = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b0;
        #1;
        model_reset();
        q0.delete();
        q1.delete();
        rv = model_vec(0);
        check("midrst_x", 64'(x0), 64'(rv[N*W +: N*W]));
        check("midrst_y", 64'(y0), 64'(rv[0 +: N*W]));
        check("midrst_busy", busy0, 0);
        check("midrst_ovr", ovr0, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            if (done0) check("midrst_done", done0, 0);
        end
        @(negedge Clk) Reset_n = 1'b1;

        run_frame(8'h00, 0, 0, "post");
        check("post_o1x", x0[W +: W], 63);
        check("post_o2x", x0[2*W +: W], 129);
        check("post_ovr", ovr0, 0);
        run_frame(8'h07, 1, 0, "post_pause");
        check("post_pause_o0x", x0[0 +: W], 320);
        check("post_pause_o1x", x0[W +: W], 63);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
